// File: rtl/case_6_sdiv_10s_8s_8_seq_1_pkg.sv
// Shared types and helpers for the sequential signed divider.
package case_6_div_pkg;

  // Default operand and result widths of the standard instance.
  localparam int DIN0_W_DEF = 10;
  localparam int DIN1_W_DEF = 8;
  localparam int DOUT_W_DEF = 8;

  // Working width of the sign-magnitude helper; callers size-cast in and out.
  localparam int MAX_W = 32;

  // Controller states: waiting for a request, shifting, applying signs.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  // Width of an iteration counter able to hold the value 'width'.
  function automatic int cnt_w(input int width);
    return $clog2(width + 32'sd1);
  endfunction

  // Conditional two's-complement negate: abs() when negate is the sign bit,
  // sign restoration when negate is a stored sign flag.
  function automatic logic [MAX_W-1:0] sign_mag(input logic [MAX_W-1:0] value,
                                                input logic             negate);
    logic [MAX_W-1:0] result;
    if (negate) begin
      result = {MAX_W{1'b0}} - value;
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/case_6_sdiv_10s_8s_8_seq_1_if.sv
// Request/result bundle of the sequential divider: the datapath side is the
// master (drives operands and control), the divider is the slave.
interface case_6_sdiv_10s_8s_8_seq_1_if
  import case_6_div_pkg::*;
#(
  parameter int din0_WIDTH = DIN0_W_DEF,
  parameter int din1_WIDTH = DIN1_W_DEF,
  parameter int dout_WIDTH = DOUT_W_DEF
);

  logic                         ce;
  logic                         start;
  logic signed [din0_WIDTH-1:0] dividend0;
  logic signed [din1_WIDTH-1:0] divisor0;
  logic                         done;
  logic        [dout_WIDTH-1:0] quot;
  logic        [dout_WIDTH-1:0] remd;

  modport master (
    output ce, start, dividend0, divisor0,
    input  done, quot, remd
  );

  modport slave (
    input  ce, start, dividend0, divisor0,
    output done, quot, remd
  );

endinterface

// File: rtl/case_6_sdiv_10s_8s_8_seq_1_step.sv
// One restoring-division step on magnitudes: shift the partial remainder,
// bring in one dividend bit, trial-subtract the divisor and keep the
// difference only when it did not go negative.
module case_6_sdiv_10s_8s_8_seq_1_step #(
  parameter int DIV_W = 8
) (
  input  logic [DIV_W:0]   rem,
  input  logic             din_bit,
  input  logic [DIV_W-1:0] dmag,
  output logic [DIV_W:0]   rem_next,
  output logic             qbit
);

  logic [DIV_W+1:0] shifted;
  logic [DIV_W+1:0] trial;
  logic             dmag_zero;

  // Trial subtract; the top bit of the difference is its sign. A zero divisor
  // always succeeds, and then difference and restore value are identical.
  always_comb begin
    shifted   = {rem, din_bit};
    trial     = shifted - {2'b00, dmag};
    dmag_zero = (dmag == {DIV_W{1'b0}});
    qbit      = ~trial[DIV_W+1] | dmag_zero;
    if (qbit) begin
      rem_next = trial[DIV_W:0];
    end else begin
      rem_next = shifted[DIV_W:0];
    end
  end

endmodule

// File: rtl/case_6_sdiv_10s_8s_8_seq_1.sv
// Sequential signed divider with C semantics (quotient truncates toward zero,
// remainder takes the dividend's sign). One quotient bit per enabled clock.
module case_6_sdiv_10s_8s_8_seq_1
  import case_6_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 11,
  parameter int din0_WIDTH = DIN0_W_DEF,
  parameter int din1_WIDTH = DIN1_W_DEF,
  parameter int dout_WIDTH = DOUT_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  case_6_sdiv_10s_8s_8_seq_1_if.slave  bus
);

  localparam int CNT_W = cnt_w(din0_WIDTH);
  localparam int REM_W = din1_WIDTH + 1;

  // Configuration sanity: latency tag must match the iteration count, and the
  // remainder register must be at least as wide as the output.
  if ((NUM_STAGE != din0_WIDTH + 32'sd1) || (ID < 32'sd0) ||
      (dout_WIDTH > REM_W) || (dout_WIDTH > din0_WIDTH)) begin : g_cfg_err
    $error("case_6_sdiv_10s_8s_8_seq_1: inconsistent parameters");
  end

  div_state_t             state;
  div_state_t             state_next;
  logic                   accept;
  logic                   iter_en;
  logic                   fix_en;

  logic [CNT_W-1:0]       count;
  logic [din0_WIDTH-1:0]  dq;        // dividend bits shift out, quotient bits shift in
  logic [REM_W-1:0]       rem;
  logic [REM_W-1:0]       rem_next;
  logic [din1_WIDTH-1:0]  dmag;
  logic                   sign_q;
  logic                   sign_r;
  logic                   qbit;

  logic [din0_WIDTH-1:0]  dvd_mag_in;
  logic [din1_WIDTH-1:0]  dvs_mag_in;
  logic                   sign_q_in;
  logic [dout_WIDTH-1:0]  quot_fix;
  logic [dout_WIDTH-1:0]  remd_fix;

  logic                   done_r;
  logic [dout_WIDTH-1:0]  quot_r;
  logic [dout_WIDTH-1:0]  remd_r;

  case_6_sdiv_10s_8s_8_seq_1_step #(
    .DIV_W (din1_WIDTH)
  ) u_step (
    .rem      (rem),
    .din_bit  (dq[din0_WIDTH-1]),
    .dmag     (dmag),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  // Next-state decode; starts outside IDLE are simply not looked at.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    iter_en    = 1'b0;
    fix_en     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = ITER;
          accept     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      ITER: begin
        iter_en = 1'b1;
        if (count == CNT_W'(32'd1)) begin
          state_next = FIX;
        end else begin
          state_next = ITER;
        end
      end
      FIX: begin
        fix_en     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; advances only on clock-enabled edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else if (bus.ce) begin
      state <= state_next;
    end
  end

  // Operand magnitudes on the way in, signed results on the way out.
  // The most negative dividend maps onto its unsigned magnitude (-512 -> 512).
  always_comb begin
    dvd_mag_in = din0_WIDTH'(sign_mag(MAX_W'(bus.dividend0), bus.dividend0[din0_WIDTH-1]));
    dvs_mag_in = din1_WIDTH'(sign_mag(MAX_W'(bus.divisor0), bus.divisor0[din1_WIDTH-1]));
    sign_q_in  = bus.dividend0[din0_WIDTH-1] ^ bus.divisor0[din1_WIDTH-1];
    quot_fix   = dout_WIDTH'(sign_mag(MAX_W'(dq), sign_q));
    remd_fix   = dout_WIDTH'(sign_mag(MAX_W'(rem), sign_r));
  end

  // Iteration datapath: capture on accept, one restoring step per ITER edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= {CNT_W{1'b0}};
      dq     <= {din0_WIDTH{1'b0}};
      rem    <= {REM_W{1'b0}};
      dmag   <= {din1_WIDTH{1'b0}};
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else if (bus.ce) begin
      if (accept) begin
        count  <= CNT_W'(din0_WIDTH);
        dq     <= dvd_mag_in;
        rem    <= {REM_W{1'b0}};
        dmag   <= dvs_mag_in;
        sign_q <= sign_q_in;
        sign_r <= bus.dividend0[din0_WIDTH-1];
      end else if (iter_en) begin
        count  <= count - CNT_W'(32'd1);
        dq     <= {dq[din0_WIDTH-2:0], qbit};
        rem    <= rem_next;
      end
    end
  end

  // Result registers: loaded once per operation in FIX, held otherwise;
  // done is a single enabled-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_r <= 1'b0;
      quot_r <= {dout_WIDTH{1'b0}};
      remd_r <= {dout_WIDTH{1'b0}};
    end else if (bus.ce) begin
      done_r <= fix_en;
      if (fix_en) begin
        quot_r <= quot_fix;
        remd_r <= remd_fix;
      end
    end
  end

  assign bus.done = done_r;
  assign bus.quot = quot_r;
  assign bus.remd = remd_r;

endmodule

// File: tb/tb_case_6_sdiv_10s_8s_8_seq_1.sv
// Scoreboard bench for the sequential signed divider: stimulus pushes the
// C-semantics expectation, a negedge monitor pops and compares on done.
module tb_case_6_sdiv_10s_8s_8_seq_1;

  localparam int W0   = 10;
  localparam int W1   = 8;
  localparam int WO   = 8;
  localparam int LAT  = W0 + 1;
  localparam int QMAX = (1 << W0) - 1;

  typedef struct {
    logic [WO-1:0] q;
    logic [WO-1:0] r;
    int            due;
    int            a;
    int            b;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  case_6_sdiv_10s_8s_8_seq_1_if #(.din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(WO)) bus ();

  case_6_sdiv_10s_8s_8_seq_1 #(
    .ID(1), .NUM_STAGE(LAT), .din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(WO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            ce_edges = 0;
  logic          ce_last  = 1'b0;
  logic          rst_last = 1'b1;
  bit            mon_on   = 1'b0;
  logic          mon_prev_done = 1'b0;
  logic [WO-1:0] mon_held_q = '0;
  logic [WO-1:0] mon_held_r = '0;

  // Count clock-enabled edges; latency is measured in these.
  always @(posedge clk) begin
    ce_last  <= bus.ce;
    rst_last <= reset;
    if (!reset && bus.ce) ce_edges <= ce_edges + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: C division rules; zero divisor gives all-ones magnitude.
  function automatic exp_t model(input int a, input int b);
    exp_t m;
    int   q;
    int   r;
    if (b == 0) begin
      q = (a < 0) ? -QMAX : QMAX;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
    m.q = q[WO-1:0];
    m.r = r[WO-1:0];
    m.due = 0;
    m.a = a;
    m.b = b;
    return m;
  endfunction

  // Monitor: compare on each new done, check pulse width, hold and stability.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (rst_last) begin
          mon_held_q    = '0;
          mon_held_r    = '0;
          mon_prev_done = 1'b0;
        end
        if (mon_prev_done && ce_last) check("done_pulse", 32'(bus.done), 32'd0);
        else if (mon_prev_done) check("done_hold", 32'(bus.done), 32'd1);
        if (bus.done && !mon_prev_done) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done with quot=0x%0h remd=0x%0h, want none", bus.quot, bus.remd);
          end else begin
            e = sb.pop_front();
            check($sformatf("quot(%0d/%0d)", e.a, e.b), 32'(bus.quot), 32'(e.q));
            check($sformatf("remd(%0d/%0d)", e.a, e.b), 32'(bus.remd), 32'(e.r));
            check("latency_ce_edges", ce_edges, e.due);
            mon_held_q = e.q;
            mon_held_r = e.r;
          end
        end else begin
          check("quot_stable", 32'(bus.quot), 32'(mon_held_q));
          check("remd_stable", 32'(bus.remd), 32'(mon_held_r));
        end
        mon_prev_done = bus.done;
      end
    end
  end

  // One operation. mode 1: random ce; else ce low gap_len cycles after gap_at
  // enabled edges. extra: random start pulses while busy. hold_end: ce-low
  // cycles after done. clocks: clock edges from accept to done.
  task automatic do_op(input int a, input int b, input int mode, input int gap_at,
                       input int gap_len, input bit extra, input int hold_end,
                       output int clocks);
    int   base;
    int   k;
    int   gapped;
    int   cyc;
    exp_t e;
    bus.dividend0 = W0'(a);
    bus.divisor0  = W1'(b);
    bus.start     = 1'b1;
    bus.ce        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    base  = ce_edges;
    e     = model(a, b);
    e.due = base + LAT;
    sb.push_back(e);
    bus.dividend0 = W0'($urandom);
    bus.divisor0  = W1'($urandom);
    gapped = 0;
    cyc    = 0;
    while (ce_edges < base + LAT && cyc < 200) begin
      k = ce_edges - base;
      if (mode == 1) bus.ce = ($urandom_range(3) != 0);
      else if (k == gap_at && gapped < gap_len) begin
        bus.ce = 1'b0;
        gapped++;
      end else bus.ce = 1'b1;
      bus.start = (extra && k <= LAT - 2) ? 1'($urandom_range(1)) : 1'b0;
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    bus.ce    = 1'b1;
    clocks    = cyc;
    if (ce_edges != base + LAT) begin
      n_checks++;
      n_fail++;
      $display("FAIL op_timeout: got %0d enabled edges, want %0d", ce_edges - base, LAT);
    end
    for (int i = 0; i < hold_end; i++) begin
      bus.ce = 1'b0;
      @(negedge clk);
    end
    bus.ce = 1'b1;
  endtask

  initial begin : stim
    int clocks;
    int a;
    int b;
    bus.ce = 1'b0;
    bus.start = 1'b0;
    bus.dividend0 = '0;
    bus.divisor0 = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    bus.ce = 1'b1;
    @(negedge clk);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_quot", 32'(bus.quot), 32'd0);
    check("reset_remd", 32'(bus.remd), 32'd0);
    reset = 1'b0;
    mon_on = 1'b1;

    do_op(100, 7, 0, -1, 0, 1'b0, 0, clocks);
    check("latency_clk_100_7", clocks, LAT);
    do_op(-100, 7, 0, -1, 0, 1'b0, 0, clocks);
    do_op(100, -7, 0, -1, 0, 1'b0, 0, clocks);
    do_op(-100, -7, 0, -1, 0, 1'b0, 0, clocks);
    do_op(-512, -1, 0, -1, 0, 1'b0, 0, clocks);
    do_op(37, 0, 0, -1, 0, 1'b0, 0, clocks);
    do_op(-37, 0, 0, -1, 0, 1'b0, 0, clocks);
    do_op(-512, 0, 0, -1, 0, 1'b0, 0, clocks);
    do_op(511, -128, 0, -1, 0, 1'b0, 0, clocks);
    // ce low for 5 cycles mid-iteration, then ce low while done is up
    do_op(100, 7, 0, 3, 5, 1'b0, 3, clocks);
    check("latency_clk_gap", clocks, LAT + 5);
    // stray starts while busy, then a back-to-back operation
    do_op(100, 7, 0, -1, 0, 1'b1, 0, clocks);
    do_op(-128, 3, 0, -1, 0, 1'b0, 0, clocks);
    check("latency_clk_b2b", clocks, LAT);

    // abort in the middle of an operation
    bus.dividend0 = W0'(100);
    bus.divisor0  = W1'(7);
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_quot", 32'(bus.quot), 32'd0);
    check("abort_remd", 32'(bus.remd), 32'd0);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    do_op(-128, 3, 0, -1, 0, 1'b0, 0, clocks);
    check("latency_clk_after_abort", clocks, LAT);

    // randomized operations with random ce, stray starts and idle gaps
    for (int n = 0; n < 60; n++) begin
      a = int'($urandom_range(QMAX)) - (1 << (W0 - 1));
      b = int'($urandom_range((1 << W1) - 1)) - (1 << (W1 - 1));
      if ($urandom_range(9) == 0) b = 0;
      do_op(a, b, 1, -1, 0, 1'($urandom_range(1)), int'($urandom_range(2)), clocks);
      repeat ($urandom_range(3)) begin
        bus.ce = 1'($urandom_range(1));
        @(negedge clk);
      end
      bus.ce = 1'b1;
    end

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missing_done: got no result for %0d/%0d, want quot=0x%0h remd=0x%0h", e.a, e.b, e.q, e.r);
    end
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
